// File: rtl/series_adder_job_arbiter_pkg.sv
// Shared types for the series adder job arbiter: FSM state encoding and
// the id-width helper used to sanity-check grant_id sizing.
package series_adder_job_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    WAIT    = 3'd4
  } state_e;

  // ceil(log2(n)), never below 1 so a single-bit id still exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/series_adder_job_arbiter_rr_arbiter.sv
// Combinational round-robin search: first asserted req after ptr, with wrap.
module series_adder_job_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  // Scan farthest offset first so the nearest requester after ptr is the last to overwrite.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/series_adder_job_arbiter.sv
// Round-robin sharing of one series adder wrapper between NUM_REQ job
// requesters; input words and results are passed through without buffering.
module series_adder_job_arbiter
  import series_adder_job_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic                      add_idle,
  output logic                      add_data_vld,
  input  logic                      add_data_rdy,
  output logic [DATA_W-1:0]         add_data,
  input  logic [DATA_W-1:0]         add_result,
  input  logic                      add_result_vld,
  input  logic                      add_result_first,
  input  logic                      add_result_last,
  output logic                      add_result_rdy,
  output logic [DATA_W-1:0]         res_data,
  output logic [NUM_REQ-1:0]        res_vld,
  output logic                      res_first,
  output logic                      res_last,
  input  logic [NUM_REQ-1:0]        res_rdy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      err
);

  if (ID_W != clog2_min1(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ), minimum 1");
  end

  state_e                           state, state_nxt;
  logic [ID_W-1:0]                  ptr, ptr_nxt, grant_nxt;
  logic                             in_done, in_done_nxt;
  logic                             res_done, res_done_nxt;
  logic                             rvld_q;
  logic [ID_W-1:0]                  pick;
  logic                             pick_any;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_words;
  logic                             g_vld, g_last, g_res_rdy;
  logic                             fwd_in, fwd_res;

  assign req_words = req_data;
  assign g_vld     = req_vld[grant_id];
  assign g_last    = req_last[grant_id];
  assign g_res_rdy = res_rdy[grant_id];
  assign fwd_in    = (state == HDR) || (state == PAYLOAD);
  assign fwd_res   = fwd_in || (state == WAIT);
  assign busy      = (state != IDLE);

  series_adder_job_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req (req_vld),
    .ptr (ptr),
    .idx (pick),
    .any (pick_any)
  );

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    grant_nxt      = grant_id;
    in_done_nxt    = in_done;
    res_done_nxt   = res_done;
    req_rdy        = '0;
    add_data_vld   = 1'b0;
    add_data       = '0;
    add_result_rdy = 1'b0;
    res_vld        = '0;
    res_data       = '0;
    res_first      = 1'b0;
    res_last       = 1'b0;
    err            = 1'b0;

    if (fwd_in) begin
      add_data          = req_words[grant_id];
      add_data_vld      = g_vld;
      req_rdy[grant_id] = add_data_rdy;
    end

    // Results may overtake the end of input, so routing opens at the header.
    if (fwd_res) begin
      res_data          = add_result;
      res_first         = add_result_first;
      res_last          = add_result_last;
      res_vld[grant_id] = add_result_vld;
      add_result_rdy    = g_res_rdy;
      if (add_result_vld && g_res_rdy && add_result_last) res_done_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        err = add_result_vld && !rvld_q;
        if (add_idle && pick_any) begin
          grant_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        in_done_nxt  = 1'b0;
        res_done_nxt = 1'b0;
        state_nxt    = HDR;
      end
      HDR: begin
        // A header flagged last is malformed: swallow it, keep it from the adder.
        if (g_vld && g_last) begin
          add_data_vld      = 1'b0;
          req_rdy[grant_id] = 1'b1;
          err               = 1'b1;
          ptr_nxt           = grant_id;
          state_nxt         = IDLE;
        end else if (g_vld && add_data_rdy) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (g_vld && add_data_rdy && g_last) begin
          in_done_nxt = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (in_done && res_done_nxt) begin
          ptr_nxt   = grant_id;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rvld_q resets high so a result valid held through reset never flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      in_done  <= 1'b0;
      res_done <= 1'b0;
      rvld_q   <= 1'b1;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      in_done  <= in_done_nxt;
      res_done <= res_done_nxt;
      rvld_q   <= add_result_vld;
    end
  end

endmodule

// File: tb/tb_series_adder_job_arbiter.sv
// Bench: plays requesters and adder wrapper, checks against a job-level round-robin model.
module tb_series_adder_job_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_vld, req_rdy, req_last, res_vld, res_rdy;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic add_idle, add_data_vld, add_data_rdy, add_result_vld, add_result_first, add_result_last;
  logic add_result_rdy, res_first, res_last, busy, err;
  logic [DATA_W-1:0] add_data, add_result, res_data;
  logic [ID_W-1:0] grant_id;

  always #5 clk = ~clk;

  series_adder_job_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
    .req_last(req_last), .add_idle(add_idle), .add_data_vld(add_data_vld),
    .add_data_rdy(add_data_rdy), .add_data(add_data), .add_result(add_result),
    .add_result_vld(add_result_vld), .add_result_first(add_result_first),
    .add_result_last(add_result_last), .add_result_rdy(add_result_rdy), .res_data(res_data),
    .res_vld(res_vld), .res_first(res_first), .res_last(res_last), .res_rdy(res_rdy),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  typedef struct { logic [31:0] data; bit hdr; bit last; } word_t;
  typedef struct { int req; logic [31:0] data; bit first; bit last; } res_t;
  typedef struct { logic [31:0] data; bit first; bit last; } wres_t;
  typedef struct { int n0; int n1; bit bad1; int nseq; logic [7:0] seq; } vec_t;

  word_t jq[NUM_REQ][$];
  word_t mq[NUM_REQ][$];
  wres_t res_q[$];
  int got_grants[$], exp_grants[$], gaps[$];
  logic [31:0] got_words[$], exp_words[$];
  res_t got_res[$], exp_res[$];
  int tests, fails, got_err, exp_err, viol, mptr, cyc, first_cyc, idle_run;
  int data_stall, res_stall;
  bit busy_prev, seen_job, rnd_en, gap_en, stray, arm_data, arm_res, wtwo;
  logic [31:0] wacc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input res_t r);
    return 64'({8'(r.req), r.data, r.first, r.last});
  endfunction

  function automatic bit pending();
    bit p = (res_q.size() > 0);
    for (int i = 0; i < NUM_REQ; i++) if (jq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin jq[i].delete(); mq[i].delete(); end
    res_q.delete(); got_grants.delete(); exp_grants.delete(); gaps.delete();
    got_words.delete(); exp_words.delete(); got_res.delete(); exp_res.delete();
    got_err = 0; exp_err = 0; viol = 0; cyc = 0; first_cyc = -1; idle_run = 0;
    data_stall = 0; res_stall = 0; arm_data = 0; arm_res = 0; stray = 0;
    busy_prev = 0; seen_job = 0; wacc = '0; wtwo = 0;
  endtask

  task automatic add_job(input int r, input int len, input bit bad);
    word_t w;
    w.data = 32'(4 * len); w.hdr = 1'b1; w.last = bad;
    jq[r].push_back(w); mq[r].push_back(w);
    if (!bad) for (int k = 0; k < len; k++) begin
      w.data = $urandom; w.hdr = 1'b0; w.last = (k == len - 1);
      jq[r].push_back(w); mq[r].push_back(w);
    end
  endtask

  // Job-level model: next owner is the first requester after the last one served.
  task automatic model_run();
    int g; bit found; word_t w; logic [31:0] acc; bit two;
    forever begin
      found = 0; g = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (mptr + k) % NUM_REQ;
        if (!found && mq[c].size() > 0) begin g = c; found = 1; end
      end
      if (!found) break;
      exp_grants.push_back(g);
      w = mq[g].pop_front();
      if (w.last) exp_err++;
      else begin
        exp_words.push_back(w.data);
        two = (w.data == 32'd16);
        if (two) exp_res.push_back('{g, w.data, 1'b1, 1'b0});
        acc = '0;
        do begin
          w = mq[g].pop_front();
          exp_words.push_back(w.data);
          acc += w.data;
        end while (!w.last);
        exp_res.push_back('{g, acc, !two, 1'b1});
      end
      mptr = g;
    end
  endtask

  task automatic tick();
    word_t w; int g; res_t r;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (jq[i].size() > 0) begin
        w = jq[i][0];
        req_vld[i] = w.hdr || !gap_en || ($urandom_range(3) != 0);
        req_data[i*DATA_W +: DATA_W] = w.data;
        req_last[i] = w.last;
      end else begin
        req_vld[i] = 1'b0; req_last[i] = 1'b0;
      end
    end
    if (arm_data && jq[0].size() == 3) begin data_stall = 3; arm_data = 0; end
    if (arm_res && res_q.size() > 0) begin res_stall = 2; arm_res = 0; end
    for (int i = 0; i < NUM_REQ; i++) res_rdy[i] = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
    if (res_stall > 0) res_rdy = '0;
    add_data_rdy = (data_stall > 0) ? 1'b0 : (rnd_en ? ($urandom_range(3) != 0) : 1'b1);
    add_result_vld = stray || (res_q.size() > 0);
    if (res_q.size() > 0) begin
      add_result = res_q[0].data; add_result_first = res_q[0].first; add_result_last = res_q[0].last;
    end else begin
      add_result = '0; add_result_first = 1'b0; add_result_last = 1'b0;
    end
    add_idle = (res_q.size() == 0);
    #1;
    if (busy && !busy_prev) begin
      got_grants.push_back(int'(grant_id));
      if (seen_job) gaps.push_back(idle_run);
      seen_job = 1;
    end
    if (busy) idle_run = 0; else idle_run++;
    busy_prev = busy;
    if (err) got_err++;
    if (data_stall > 0) begin chk("stall_req_rdy", 64'({req_rdy, add_data_vld}), 64'(3'b001)); data_stall--; end
    if (res_stall > 0) begin chk("stall_res", 64'({add_result_rdy, res_vld}), 64'(3'b001)); res_stall--; end
    if (add_data_vld && add_data_rdy) begin
      g = int'(grant_id);
      if (first_cyc < 0) first_cyc = cyc;
      got_words.push_back(add_data);
      if (jq[g].size() == 0) viol++;
      else if (jq[g][0].hdr) begin
        wacc = '0; wtwo = (add_data == 32'd16);
        if (wtwo) res_q.push_back('{add_data, 1'b1, 1'b0});
      end else begin
        wacc += add_data;
        if (jq[g][0].last) res_q.push_back('{wacc, !wtwo, 1'b1});
      end
    end
    if (add_result_vld && add_result_rdy) begin
      if (res_q.size() > 0) void'(res_q.pop_front());
      r.req = -1;
      for (int i = 0; i < NUM_REQ; i++) if (res_vld[i]) r.req = i;
      if ($countones(res_vld) != 1) viol++;
      r.data = res_data; r.first = res_first; r.last = res_last;
      got_res.push_back(r);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_vld[i] && req_rdy[i]) begin
        if (!busy || i != int'(grant_id) || jq[i].size() == 0) viol++;
        else void'(jq[i].pop_front());
      end
      if (i != int'(grant_id) && (req_rdy[i] || res_vld[i])) viol++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((pending() || busy || n == 0) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL run_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic compare_run(input string tag);
    int n;
    chk({tag, "_n_grants"}, got_grants.size(), exp_grants.size());
    n = (got_grants.size() < exp_grants.size()) ? got_grants.size() : exp_grants.size();
    for (int k = 0; k < n; k++) chk({tag, "_grant"}, got_grants[k], exp_grants[k]);
    chk({tag, "_n_words"}, got_words.size(), exp_words.size());
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int k = 0; k < n; k++) chk({tag, "_word"}, got_words[k], exp_words[k]);
    chk({tag, "_n_res"}, got_res.size(), exp_res.size());
    n = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
    for (int k = 0; k < n; k++) chk({tag, "_res"}, pk(got_res[k]), pk(exp_res[k]));
    chk({tag, "_err_count"}, got_err, exp_err);
    chk({tag, "_protocol"}, viol, 0);
    got_grants.delete(); exp_grants.delete(); gaps.delete(); got_words.delete();
    exp_words.delete(); got_res.delete(); exp_res.delete();
    got_err = 0; exp_err = 0; viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '0; req_data = '0; req_last = '0; add_idle = 1'b1; add_data_rdy = 1'b0;
    add_result = '0; add_result_vld = 1'b0; add_result_first = 1'b0; add_result_last = 1'b0;
    res_rdy = '0;
    clear_all();
    mptr = NUM_REQ - 1;
    #1;
    chk("reset_outputs", 64'({busy, err, req_rdy, add_data_vld, add_result_rdy, res_vld}), 64'(0));
    chk("reset_grant_id", 64'(grant_id), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int n;
    tests = 0; fails = 0;
    vecs[0] = '{1, 0, 1'b0, 1, 8'b0000_0000};
    vecs[1] = '{1, 1, 1'b0, 2, 8'b0000_0010};
    vecs[2] = '{3, 2, 1'b0, 5, 8'b0000_1010};
    vecs[3] = '{2, 1, 1'b1, 3, 8'b0000_0010};

    for (int r = 0; r < 4; r++) begin
      do_reset();
      rnd_en = 0; gap_en = 0;
      for (int j = 0; j < vecs[r].n0; j++) add_job(0, 3, 1'b0);
      for (int j = 0; j < vecs[r].n1; j++) add_job(1, 3, vecs[r].bad1 && j == 0);
      model_run();
      cyc = 0; first_cyc = -1; seen_job = 0;
      run(500);
      chk("row_hdr_latency", first_cyc, 2);
      chk("row_n_grants", got_grants.size(), vecs[r].nseq);
      for (int k = 0; k < vecs[r].nseq && k < got_grants.size(); k++)
        chk("row_grant_seq", got_grants[k], 64'(vecs[r].seq[k]));
      chk("row_n_gaps", gaps.size(), vecs[r].nseq - 1);
      foreach (gaps[k]) chk("row_idle_gap", gaps[k], 1);
      chk("row_err_count", got_err, 64'(vecs[r].bad1));
      chk("row_end_busy", busy, 0);
      chk("row_end_grant_id", grant_id, 64'(vecs[r].seq[vecs[r].nseq-1]));
      compare_run("row");
    end

    // Backpressure on both sides mid-job; words and results must survive intact.
    do_reset();
    rnd_en = 0; gap_en = 0;
    add_job(0, 4, 1'b0);
    model_run();
    arm_data = 1; arm_res = 1;
    run(200);
    chk("bp_stalls_applied", 64'({arm_data, arm_res, 1'(data_stall > 0), 1'(res_stall > 0)}), 64'(0));
    compare_run("bp");

    // Stray result valid while idle: one err pulse per rising edge.
    do_reset();
    tick();
    stray = 1;
    tick();
    chk("stray_result_rdy", add_result_rdy, 0);
    tick(); tick();
    stray = 0;
    tick(); tick();
    chk("stray_err_pulses", got_err, 1);
    got_err = 0;

    // Asynchronous reset in the middle of a payload, then a clean job.
    do_reset();
    add_job(0, 4, 1'b0);
    n = 0;
    while (jq[0].size() > 3 && n < 20) begin tick(); n++; end
    chk("midjob_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({busy, err, req_rdy, add_data_vld, add_result_rdy, res_vld, res_first, res_last, grant_id}), 64'(0));
    chk("async_reset_res_data", res_data, 0);
    do_reset();
    add_job(0, 3, 1'b0);
    model_run();
    run(200);
    chk("post_reset_grant_id", grant_id, 0);
    compare_run("post_reset");

    // Randomized jobs with backpressure, gaps and bad headers.
    do_reset();
    rnd_en = 1; gap_en = 1;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int nj;
        nj = $urandom_range(3);
        for (int j = 0; j < nj; j++) add_job(i, $urandom_range(4, 1), $urandom_range(7) == 0);
      end
      model_run();
      run(3000);
      compare_run("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
